// File: rtl/bound_flasher_ctrl.sv
// ---------------------------------------------------------------------------
// bound_flasher_ctrl
// Next-state logic and 16-lamp level datapath for the bound flasher. The
// external state register holds main_state; this block decides where it goes
// next and owns the lamp level counter.
//
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   flick        in   1   user request, sampled on clk rising edge
//   main_state   in   3   current state from the state register
//   main_state_n out  3   next state for the state register (combinational)
//   lamp         out  16  thermometer code of the level: lamp[i] = (i < L)
// ---------------------------------------------------------------------------
module bound_flasher_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flick,
  input  logic [2:0]  main_state,
  output logic [2:0]  main_state_n,
  output logic [15:0] lamp
);

  typedef enum logic [2:0] {
    INIT  = 3'd0,
    UP_5  = 3'd1,
    DN_0  = 3'd2,
    UP_10 = 3'd3,
    DN_5  = 3'd4,
    UP_15 = 3'd5,
    DN_0F = 3'd6
  } state_t;

  localparam logic [4:0] LEVEL_MAX = 5'd16;

  logic [4:0] level_r;
  logic [4:0] level_next_s;
  logic [4:0] level_inc_s;
  logic [4:0] level_dec_s;
  logic       kick_s;
  logic [15:0] lamp_r;

  // Thermometer decode: bit i lit when i is below the level.
  function automatic logic [15:0] therm(input logic [4:0] lvl);
    logic [15:0] t;
    t = 16'h0000;
    for (int i = 0; i < 16; i++) begin
      t[i] = (5'(i) < lvl) ? 1'b1 : 1'b0;
    end
    return t;
  endfunction

  // Saturating step values so an inconsistent (state, level) pair never wraps.
  always_comb begin
    level_inc_s = 5'd0;
    level_dec_s = 5'd0;
    if (level_r >= LEVEL_MAX) begin
      level_inc_s = LEVEL_MAX;
    end else begin
      level_inc_s = level_r + 5'd1;
    end
    if (level_r == 5'd0) begin
      level_dec_s = 5'd0;
    end else if (level_r > LEVEL_MAX) begin
      level_dec_s = LEVEL_MAX;
    end else begin
      level_dec_s = level_r - 5'd1;
    end
  end

  // Kickback: flick while lamp[5] or lamp[10] is the top lit lamp in UP_10/UP_15.
  always_comb begin
    kick_s = 1'b0;
    if ((main_state == UP_10 || main_state == UP_15) && flick &&
        (level_r == 5'd6 || level_r == 5'd11)) begin
      kick_s = 1'b1;
    end else begin
      kick_s = 1'b0;
    end
  end

  // Next-state and next-level selection.
  always_comb begin
    main_state_n = INIT;
    level_next_s = 5'd0;
    case (main_state)
      INIT: begin
        level_next_s = 5'd0;
        main_state_n = flick ? UP_5 : INIT;
      end
      UP_5: begin
        level_next_s = level_inc_s;
        main_state_n = (level_inc_s == 5'd6) ? DN_0 : UP_5;
      end
      DN_0: begin
        level_next_s = level_dec_s;
        main_state_n = (level_dec_s == 5'd0) ? UP_10 : DN_0;
      end
      UP_10: begin
        if (kick_s) begin
          level_next_s = level_dec_s;
          main_state_n = DN_0;
        end else begin
          level_next_s = level_inc_s;
          main_state_n = (level_inc_s == 5'd11) ? DN_5 : UP_10;
        end
      end
      DN_5: begin
        level_next_s = level_dec_s;
        main_state_n = (level_dec_s == 5'd5) ? UP_15 : DN_5;
      end
      UP_15: begin
        if (kick_s) begin
          level_next_s = level_dec_s;
          main_state_n = DN_5;
        end else begin
          level_next_s = level_inc_s;
          main_state_n = (level_inc_s == LEVEL_MAX) ? DN_0F : UP_15;
        end
      end
      DN_0F: begin
        level_next_s = level_dec_s;
        main_state_n = (level_dec_s == 5'd0) ? INIT : DN_0F;
      end
      default: begin
        level_next_s = 5'd0;
        main_state_n = INIT;
      end
    endcase
  end

  // Level register and registered lamp image; lamp carries no path from flick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_r <= 5'd0;
      lamp_r  <= 16'h0000;
    end else begin
      level_r <= level_next_s;
      lamp_r  <= therm(level_next_s);
    end
  end

  assign lamp = lamp_r;

endmodule

// File: tb/tb_bound_flasher_ctrl.sv
// ---------------------------------------------------------------------------
// tb_bound_flasher_ctrl
// Wraps the controller with a state register, drives directed and random
// flick patterns, and checks lamp/state against a table-driven model through
// an expectation queue drained by an independent monitor.
// ---------------------------------------------------------------------------
module tb_bound_flasher_ctrl;

  logic        clk;
  logic        rst_n;
  logic        flick;
  logic [2:0]  main_state;
  logic [2:0]  main_state_n;
  logic [15:0] lamp;
  logic [2:0]  state_q;
  logic        force_ill;

  typedef struct {
    logic [15:0] lamp;
    logic [2:0]  st;
  } exp_t;

  exp_t expq[$];
  int   total_cnt = 0;
  int   pass_cnt  = 0;
  int   ms = 0;   // model state
  int   ml = 0;   // model level

  // Rule tables indexed by state: level direction, turnaround level, successor.
  int dir_t[7] = '{0, 1, -1, 1, -1, 1, -1};
  int tgt_t[7] = '{0, 6, 0, 11, 5, 16, 0};
  int nxt_t[7] = '{1, 2, 3, 4, 5, 6, 0};

  bound_flasher_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flick        (flick),
    .main_state   (main_state),
    .main_state_n (main_state_n),
    .lamp         (lamp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External state register that the controller feeds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= 3'd0;
    else        state_q <= main_state_n;
  end

  assign main_state = force_ill ? 3'd7 : state_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] lamp_of(input int lvl);
    logic [31:0] t;
    t = (32'd1 << lvl) - 32'd1;
    return t[15:0];
  endfunction

  task automatic step(input int s, input int l, input bit f, output int ns, output int nl);
    if (s > 6) begin
      ns = 0; nl = 0;
    end else if (s == 0) begin
      nl = 0; ns = f ? 1 : 0;
    end else if ((s == 3 || s == 5) && f && (l == 6 || l == 11)) begin
      nl = l - 1; ns = (s == 3) ? 2 : 4;
    end else begin
      nl = l + dir_t[s];
      if (nl < 0)  nl = 0;
      if (nl > 16) nl = 16;
      ns = (nl == tgt_t[s]) ? nxt_t[s] : s;
    end
  endtask

  // One clock: drive inputs, queue the expected post-edge response, advance model.
  task automatic cycle(input bit f, input bit ill);
    int   ns, nl;
    exp_t e;
    @(negedge clk);
    flick     = f;
    force_ill = ill;
    if (ill) begin
      #1;
      chk("illegal_next_state", {29'd0, main_state_n}, 32'd0);
    end
    step(ill ? 7 : ms, ml, f, ns, nl);
    e.lamp = lamp_of(nl);
    e.st   = 3'(ns);
    expq.push_back(e);
    ms = ns;
    ml = nl;
    @(posedge clk);
    #3;
    force_ill = 1'b0;
  endtask

  task automatic run(input int n, input bit f);
    for (int i = 0; i < n; i++) cycle(f, 1'b0);
  endtask

  task automatic chk_now(input string name, input logic [15:0] exp_lamp, input logic [2:0] exp_st);
    chk({name, "_lamp"}, {16'd0, lamp}, {16'd0, exp_lamp});
    chk({name, "_state"}, {29'd0, state_q}, {29'd0, exp_st});
  endtask

  // Monitor: every post-edge output is compared with the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #2;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("scoreboard_lamp", {16'd0, lamp}, {16'd0, e.lamp});
      chk("scoreboard_state", {29'd0, state_q}, {29'd0, e.st});
    end
  end

  initial begin
    flick = 1'b0;
    force_ill = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk_now("reset", 16'h0000, 3'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Full nominal cycle from a single-cycle pulse.
    cycle(1'b1, 1'b0);
    chk_now("k0", 16'h0000, 3'd1);
    run(6, 1'b0);  chk_now("k6",  16'h003F, 3'd2);
    run(6, 1'b0);  chk_now("k12", 16'h0000, 3'd3);
    run(11, 1'b0); chk_now("k23", 16'h07FF, 3'd4);
    run(6, 1'b0);  chk_now("k29", 16'h001F, 3'd5);
    run(11, 1'b0); chk_now("k40", 16'hFFFF, 3'd6);
    run(16, 1'b0); chk_now("k56", 16'h0000, 3'd0);
    run(3, 1'b0);  chk_now("init_hold", 16'h0000, 3'd0);

    // Kickback in UP_10 at L=6, then in UP_15 at L=11.
    cycle(1'b1, 1'b0);
    run(18, 1'b0); chk_now("up10_l6", 16'h003F, 3'd3);
    cycle(1'b1, 1'b0); chk_now("kick_up10", 16'h001F, 3'd2);
    run(5, 1'b0);  chk_now("kick_up10_back", 16'h0000, 3'd3);
    run(23, 1'b0); chk_now("up15_l11", 16'h07FF, 3'd5);
    cycle(1'b1, 1'b0); chk_now("kick_up15", 16'h03FF, 3'd4);
    run(5, 1'b0);  chk_now("kick_up15_back", 16'h001F, 3'd5);
    run(27, 1'b0); chk_now("kick_done", 16'h0000, 3'd0);

    // flick held through UP_5, DN_0, DN_5 and DN_0F leaves timing unchanged.
    run(13, 1'b1); chk_now("ign_k12", 16'h0000, 3'd3);
    run(11, 1'b0); chk_now("ign_k23", 16'h07FF, 3'd4);
    run(6, 1'b1);  chk_now("ign_k29", 16'h001F, 3'd5);
    run(11, 1'b0); chk_now("ign_k40", 16'hFFFF, 3'd6);
    run(16, 1'b1); chk_now("ign_k56", 16'h0000, 3'd0);

    // Asynchronous reset in the middle of UP_15.
    cycle(1'b1, 1'b0);
    run(35, 1'b0); chk_now("pre_reset", 16'h07FF, 3'd5);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("async_reset_lamp", {16'd0, lamp}, 32'd0);
    ms = 0; ml = 0;
    @(negedge clk);
    rst_n = 1'b1;
    run(20, 1'b0); chk_now("post_reset_idle", 16'h0000, 3'd0);

    // Illegal state code from the middle of a sequence.
    cycle(1'b1, 1'b0);
    run(8, 1'b0);
    cycle(1'b0, 1'b1); chk_now("illegal", 16'h0000, 3'd0);

    // Randomised flick, occasional illegal state, occasional reset.
    for (int i = 0; i < 4000; i++) begin
      if (i % 997 == 996) begin
        @(negedge clk);
        rst_n = 1'b0;
        ms = 0; ml = 0;
        @(negedge clk);
        rst_n = 1'b1;
      end
      cycle(($urandom_range(0, 11) == 0), ($urandom_range(0, 299) == 0));
    end
    run(150, 1'b1);

    @(posedge clk);
    #4;
    chk("queue_drained", expq.size(), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
